// File: rtl/ddc_phase_sched_pkg.sv
// ddc_phase_sched_pkg: shared FSM encoding and default widths/latencies for the DDC phase scheduler
package ddc_phase_sched_pkg;
  localparam int PHASE_W_DEF = 20;
  localparam int SETTLE_CYC_DEF = 16;
  typedef enum logic [2:0] {IDLE, LOAD, RESYNC, SETTLE, DONE} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ddc_phase_sched_if.sv
// ddc_phase_sched_if: shadow-table config, apply request and DDC-facing outputs of the scheduler
interface ddc_phase_sched_if
  import ddc_phase_sched_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int PHASE_W = PHASE_W_DEF
);
  localparam int CH_W = idx_w(N_CH);
  logic cfg_we;
  logic [CH_W-1:0] cfg_ch;
  logic [PHASE_W-1:0] cfg_pinc;
  logic [PHASE_W-1:0] cfg_poff;
  logic apply;
  logic [N_CH-1:0] apply_mask;
  logic resync_en;
  logic [PHASE_W-1:0] pinc;
  logic [PHASE_W-1:0] poff;
  logic [N_CH-1:0] p_valid;
  logic resync;
  logic busy;
  logic done;
  logic data_ok;
  logic cfg_err;
  modport master (
    output cfg_we, cfg_ch, cfg_pinc, cfg_poff, apply, apply_mask, resync_en,
    input pinc, poff, p_valid, resync, busy, done, data_ok, cfg_err
  );
  modport slave (
    input cfg_we, cfg_ch, cfg_pinc, cfg_poff, apply, apply_mask, resync_en,
    output pinc, poff, p_valid, resync, busy, done, data_ok, cfg_err
  );
endinterface

// File: rtl/ddc_settle_timer.sv
// ddc_settle_timer: loadable down-counter; tc is high once the count has run down to zero
module ddc_settle_timer
  import ddc_phase_sched_pkg::*;
#(
  parameter int W = 5
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic [W-1:0] load_val,
  output logic tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else cnt <= load ? load_val : (cnt != '0 ? cnt - 1'b1 : cnt);
  assign tc = cnt == '0;
endmodule

// File: rtl/ddc_phase_sched.sv
// ddc_phase_sched: shadow table of per-DDC phase words, loaded one channel per cycle,
// followed by optional resync and a settle window before data is trusted again
module ddc_phase_sched
  import ddc_phase_sched_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input logic clk,
  input logic rstn,
  ddc_phase_sched_if.slave bus
);
  localparam int CH_W = idx_w(N_CH);
  localparam int TW = $clog2(SETTLE_CYC + 1);
  state_t state;
  logic [PHASE_W-1:0] tbl_pinc [N_CH];
  logic [PHASE_W-1:0] tbl_poff [N_CH];
  logic [CH_W-1:0] cnt, nxt;
  logic [N_CH-1:0] mask;
  logic rs_en, last, wr_ok, fwd0, settle_load, tc;
  always_comb begin
    nxt = cnt + 1'b1;
    last = cnt == CH_W'(N_CH - 1);
    wr_ok = bus.cfg_we && state == IDLE && int'(bus.cfg_ch) < N_CH;
    fwd0 = wr_ok && bus.cfg_ch == '0;
    settle_load = (state == LOAD && last && !rs_en) || state == RESYNC;
  end
  ddc_settle_timer #(.W(TW)) u_settle (
    .clk,
    .rstn,
    .load(settle_load),
    .load_val(TW'(SETTLE_CYC - 1)),
    .tc
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
      mask <= '0;
      rs_en <= 1'b0;
      bus.pinc <= '0;
      bus.poff <= '0;
      bus.p_valid <= '0;
      bus.resync <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.data_ok <= 1'b0;
      bus.cfg_err <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        tbl_pinc[i] <= '0;
        tbl_poff[i] <= '0;
      end
    end else begin
      bus.p_valid <= '0;
      bus.resync <= 1'b0;
      bus.done <= 1'b0;
      if (wr_ok) begin
        tbl_pinc[bus.cfg_ch] <= bus.cfg_pinc;
        tbl_poff[bus.cfg_ch] <= bus.cfg_poff;
      end
      if ((bus.cfg_we && !wr_ok) || (bus.apply && state != IDLE)) bus.cfg_err <= 1'b1;
      case (state)
        IDLE: if (bus.apply) begin
          state <= LOAD;
          cnt <= '0;
          mask <= bus.apply_mask;
          rs_en <= bus.resync_en;
          bus.busy <= 1'b1;
          bus.data_ok <= 1'b0;
          bus.p_valid <= N_CH'(bus.apply_mask[0]);
          // a same-cycle write to entry 0 must be seen by the first load cycle
          bus.pinc <= fwd0 ? bus.cfg_pinc : tbl_pinc[0];
          bus.poff <= fwd0 ? bus.cfg_poff : tbl_poff[0];
        end
        LOAD: if (last) begin
          state <= rs_en ? RESYNC : SETTLE;
          bus.resync <= rs_en;
        end else begin
          cnt <= nxt;
          bus.p_valid <= mask & (N_CH'(1) << nxt);
          bus.pinc <= tbl_pinc[nxt];
          bus.poff <= tbl_poff[nxt];
        end
        RESYNC: state <= SETTLE;
        SETTLE: if (tc) begin
          state <= DONE;
          bus.done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          bus.busy <= 1'b0;
          bus.data_ok <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
